line_follow_sequencer: RTL

- Sequences the servo direction command for the line follower and feeds `servo_direction` of `servo_handler`.
- Replaces the direct sensor-to-direction mapping with:
  - debounced sensors
  - minimum direction hold time
  - line-gap ride-through
  - bounded search sweep when the line is lost
- Sits between the raw sensor/switch inputs and `servo_handler`, in `main`.

---
 rtl/line_follow_pkg.sv | 34 +++
 rtl/sensor_debounce.sv | 34 +++
 rtl/line_follow_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/line_follow_pkg.sv
// Shared direction codes, FSM state codes and small helpers for the line follower
// (main, servo_handler and line_follow_sequencer all import this package).
package line_follow_pkg;

  localparam logic [1:0] DIR_REST    = 2'b00;
  localparam logic [1:0] DIR_LEFT    = 2'b01;
  localparam logic [1:0] DIR_RIGHT   = 2'b11;
  localparam logic [1:0] DIR_FORWARD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_GAP    = 3'd2,
    ST_SEARCH = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Filtered sensor pair {left, right} to steering direction; 00 maps to REST (no line).
  function automatic logic [1:0] desired_dir(input logic [1:0] f);
    logic [1:0] d;
    case (f)
      2'b11:   d = DIR_FORWARD;
      2'b10:   d = DIR_LEFT;
      2'b01:   d = DIR_RIGHT;
      default: d = DIR_REST;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] opposite_turn(input logic [1:0] t);
    return (t == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One-bit debouncer: the filtered value follows raw only after raw has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filtered
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // The edge that would bring the count to DEBOUNCE_CYCLES commits the new value instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (raw == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q  <= '0;
      filt_q <= raw;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign filtered = filt_q;

endmodule

// File: rtl/line_follow_sequencer.sv
// Servo direction sequencer: debounced sensors, minimum direction hold, gap ride-through
// and, with LINE_FOLLOW_SEARCH_EN defined, a bounded search sweep before giving up (HALT).
module line_follow_sequencer
  import line_follow_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_HOLD        = 8,
  parameter int LOST_TIMEOUT    = 16,
  parameter int SWEEP_CYCLES    = 10,
  parameter int MAX_SWINGS      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sensor,
  input  logic       enable,
  output logic [1:0] servo_direction,
  output logic       lost,
  output logic [2:0] state_dbg
);

  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam int GW = $clog2(LOST_TIMEOUT + 1);

  logic [1:0] filt;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
    .clk      (clk),
    .rst      (rst),
    .raw      (sensor[1]),
    .filtered (filt[1])
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
    .clk      (clk),
    .rst      (rst),
    .raw      (sensor[0]),
    .filtered (filt[0])
  );

  state_t        state_q, state_n;
  logic [1:0]    dir_q, dir_n;
  logic          lost_q, lost_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [GW-1:0] gap_q, gap_n;
  logic [1:0]    last_turn_q, last_turn_n;

`ifdef LINE_FOLLOW_SEARCH_EN
  localparam int SW = $clog2(SWEEP_CYCLES + 1);
  localparam int NW = $clog2(MAX_SWINGS + 1);
  logic [SW-1:0] sweep_q, sweep_n;
  logic [NW-1:0] swing_q, swing_n;
`endif

  // Hold rule shared by FOLLOW and GAP->FOLLOW re-entry.
  logic [1:0]    want;
  logic          hold_done;
  logic [HW-1:0] hold_inc;
  logic [1:0]    follow_dir;
  logic [HW-1:0] follow_hold;

  always_comb begin
    want        = desired_dir(filt);
    hold_done   = (hold_q == HW'(MIN_HOLD));
    hold_inc    = hold_done ? hold_q : hold_q + 1'b1;
    follow_dir  = dir_q;
    follow_hold = hold_inc;
    if (want != dir_q && hold_done) begin
      follow_dir  = want;
      follow_hold = '0;
    end
  end

  always_comb begin
    state_n     = state_q;
    dir_n       = dir_q;
    lost_n      = lost_q;
    hold_n      = hold_q;
    gap_n       = gap_q;
    last_turn_n = last_turn_q;
`ifdef LINE_FOLLOW_SEARCH_EN
    sweep_n     = sweep_q;
    swing_n     = swing_q;
`endif

    case (state_q)
      ST_IDLE: begin
        dir_n  = DIR_REST;
        lost_n = 1'b0;
        if (enable) begin
          state_n = ST_FOLLOW;
          hold_n  = HW'(MIN_HOLD);
        end
      end

      ST_FOLLOW: begin
        if (filt == 2'b00) begin
          state_n = ST_GAP;
          gap_n   = '0;
          hold_n  = hold_inc;
        end else begin
          dir_n  = follow_dir;
          hold_n = follow_hold;
          if (follow_dir == DIR_LEFT || follow_dir == DIR_RIGHT) last_turn_n = follow_dir;
        end
      end

      ST_GAP: begin
        if (filt != 2'b00) begin
          state_n = ST_FOLLOW;
          dir_n   = follow_dir;
          hold_n  = follow_hold;
          if (follow_dir == DIR_LEFT || follow_dir == DIR_RIGHT) last_turn_n = follow_dir;
        end else if (gap_q == GW'(LOST_TIMEOUT - 1)) begin
`ifdef LINE_FOLLOW_SEARCH_EN
          state_n = ST_SEARCH;
          dir_n   = opposite_turn(last_turn_q);
          sweep_n = '0;
          swing_n = '0;
`else
          state_n = ST_HALT;
          dir_n   = DIR_REST;
          lost_n  = 1'b1;
`endif
        end else begin
          gap_n = gap_q + 1'b1;
        end
      end

`ifdef LINE_FOLLOW_SEARCH_EN
      ST_SEARCH: begin
        // Reacquisition wins over a swing expiring on the same cycle.
        if (filt != 2'b00) begin
          state_n = ST_FOLLOW;
          hold_n  = HW'(MIN_HOLD);
        end else if (sweep_q == SW'(SWEEP_CYCLES - 1)) begin
          if (swing_q == NW'(MAX_SWINGS - 1)) begin
            state_n = ST_HALT;
            dir_n   = DIR_REST;
            lost_n  = 1'b1;
          end else begin
            swing_n = swing_q + 1'b1;
            sweep_n = '0;
            dir_n   = opposite_turn(dir_q);
          end
        end else begin
          sweep_n = sweep_q + 1'b1;
        end
      end
`endif

      ST_HALT: begin
        dir_n  = DIR_REST;
        lost_n = 1'b1;
      end

      default: begin
        state_n = ST_IDLE;
        dir_n   = DIR_REST;
        lost_n  = 1'b0;
      end
    endcase

    if (!enable) begin
      state_n = ST_IDLE;
      dir_n   = DIR_REST;
      lost_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_REST;
      lost_q      <= 1'b0;
      hold_q      <= '0;
      gap_q       <= '0;
      last_turn_q <= DIR_LEFT;
`ifdef LINE_FOLLOW_SEARCH_EN
      sweep_q     <= '0;
      swing_q     <= '0;
`endif
    end else begin
      state_q     <= state_n;
      dir_q       <= dir_n;
      lost_q      <= lost_n;
      hold_q      <= hold_n;
      gap_q       <= gap_n;
      last_turn_q <= last_turn_n;
`ifdef LINE_FOLLOW_SEARCH_EN
      sweep_q     <= sweep_n;
      swing_q     <= swing_n;
`endif
    end
  end

  assign servo_direction = dir_q;
  assign lost            = lost_q;
  assign state_dbg       = state_q;

endmodule
